// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC sequencing, single outstanding imem request, and a small
// in-order instruction buffer presented to decode over valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [15:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [ADDR_WIDTH-1:0] hold_next;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic [ADDR_WIDTH-1:0] pc_plus2;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_after_push;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc    [FIFO_DEPTH];

    assign target_aligned   = redirect_target & ~ADDR_WIDTH'(1);
    assign pc_plus2         = fetch_pc + ADDR_WIDTH'(2);
    assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);

    // Head of the buffer is shown straight from storage
    assign instr_valid = (count != '0);
    assign instruction = mem_instr[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        hold_next  = hold_addr;
        push       = 1'b0;
        flush      = redirect_valid;
        pop        = instr_valid && instr_ready && !redirect_valid;
        imem_req   = 1'b0;
        imem_addr  = fetch_pc;

        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_next = target_aligned;
                end else if (count < CNT_W'(FIFO_DEPTH)) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // In-flight word belongs to the old path; drop it now or on its ack
                    pc_next    = target_aligned;
                    hold_next  = fetch_pc;
                    state_next = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    pc_next    = pc_plus2;
                    state_next = (count_after_push < CNT_W'(FIFO_DEPTH)) ? S_WAIT : S_IDLE;
                end
            end
            S_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = hold_addr;
                if (redirect_valid) begin
                    pc_next = target_aligned;
                end
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            fetch_pc  <= pc_next;
            hold_addr <= hold_next;
        end
    end

    // Instruction buffer; flush takes priority over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_instr <= '{default: '0};
            mem_pc    <= '{default: '0};
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]    <= fetch_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table plus
// hand sequences for back-pressure and asynchronous reset.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [15:0] instr_pc;

    int tests;
    int fails;

    typedef struct {
        logic        redir;
        logic [15:0] tgt;
        logic        ack;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] pc;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    instruction_fetch_unit #(
        .ADDR_WIDTH(16),
        .RESET_PC  (16'h0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of address
    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic vec_t mk(input logic redir, input logic [15:0] tgt,
                                input logic ack, input logic rdy,
                                input logic req, input logic [15:0] addr,
                                input logic vld, input logic [15:0] pc);
        vec_t v;
        v.redir = redir; v.tgt = tgt; v.ack = ack; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string tag, input int idx, input string field,
                       input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, field, got, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), check, advance
    task automatic apply(input string tag, input int idx, input vec_t v);
        redirect_valid  = v.redir;
        redirect_target = v.tgt;
        imem_ack        = v.ack;
        imem_rdata      = v.ack ? word_at(v.addr) : 16'hDEAD;
        instr_ready     = v.rdy;
        #1;
        chk(tag, idx, "imem_req", 16'(imem_req), 16'(v.req));
        if (v.req) chk(tag, idx, "imem_addr", imem_addr, v.addr);
        else       chk(tag, idx, "imem_addr_idle", imem_addr, v.addr);
        chk(tag, idx, "instr_valid", 16'(instr_valid), 16'(v.vld));
        if (v.vld) begin
            chk(tag, idx, "instr_pc", instr_pc, v.pc);
            chk(tag, idx, "instruction", instruction, word_at(v.pc));
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 0, "imem_req", 16'(imem_req), 16'h0);
        chk(tag, 0, "imem_addr", imem_addr, 16'h0000);
        chk(tag, 0, "instr_valid", 16'(instr_valid), 16'h0);
        chk(tag, 0, "instruction", instruction, 16'h0000);
        chk(tag, 0, "instr_pc", instr_pc, 16'h0000);
    endtask

    task automatic idle_inputs();
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        imem_ack        = 1'b0;
        imem_rdata      = 16'h0000;
        instr_ready     = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst_n = 1'b0;

        //        redir tgt       ack rdy  req addr      vld pc
        tbl[0]  = mk(0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(0, 16'h0000, 1, 1,   1, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 16'h0000, 1, 1,   1, 16'h0002, 1, 16'h0000);
        tbl[3]  = mk(0, 16'h0000, 1, 1,   1, 16'h0004, 1, 16'h0002);
        tbl[4]  = mk(0, 16'h0000, 0, 1,   1, 16'h0006, 1, 16'h0004);
        tbl[5]  = mk(1, 16'h0041, 0, 1,   1, 16'h0006, 0, 16'h0000);
        tbl[6]  = mk(0, 16'h0000, 0, 1,   1, 16'h0006, 0, 16'h0000);
        tbl[7]  = mk(0, 16'h0000, 1, 1,   1, 16'h0006, 0, 16'h0000);
        tbl[8]  = mk(0, 16'h0000, 0, 1,   0, 16'h0040, 0, 16'h0000);
        tbl[9]  = mk(0, 16'h0000, 1, 1,   1, 16'h0040, 0, 16'h0000);
        tbl[10] = mk(1, 16'h0100, 1, 1,   1, 16'h0042, 1, 16'h0040);
        tbl[11] = mk(0, 16'h0000, 0, 1,   0, 16'h0100, 0, 16'h0000);
        tbl[12] = mk(0, 16'h0000, 1, 1,   1, 16'h0100, 0, 16'h0000);
        tbl[13] = mk(1, 16'hFFFF, 0, 1,   1, 16'h0102, 1, 16'h0100);
        tbl[14] = mk(0, 16'h0000, 1, 1,   1, 16'h0102, 0, 16'h0000);
        tbl[15] = mk(0, 16'h0000, 0, 1,   0, 16'hFFFE, 0, 16'h0000);
        tbl[16] = mk(0, 16'h0000, 1, 1,   1, 16'hFFFE, 0, 16'h0000);
        tbl[17] = mk(0, 16'h0000, 1, 1,   1, 16'h0000, 1, 16'hFFFE);
        tbl[18] = mk(0, 16'h0000, 0, 1,   1, 16'h0002, 1, 16'h0000);
        tbl[19] = mk(1, 16'h0200, 0, 1,   1, 16'h0002, 0, 16'h0000);
        tbl[20] = mk(1, 16'h0300, 0, 1,   1, 16'h0002, 0, 16'h0000);
        tbl[21] = mk(0, 16'h0000, 1, 1,   1, 16'h0002, 0, 16'h0000);
        tbl[22] = mk(1, 16'h0400, 0, 1,   0, 16'h0300, 0, 16'h0000);
        tbl[23] = mk(0, 16'h0000, 0, 1,   0, 16'h0400, 0, 16'h0000);
        tbl[24] = mk(0, 16'h0000, 1, 1,   1, 16'h0400, 0, 16'h0000);
        tbl[25] = mk(0, 16'h0000, 0, 1,   1, 16'h0402, 1, 16'h0400);

        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, redirects (pending, with ack, in DISCARD, in IDLE), wraparound
        for (int i = 0; i < NVEC; i++) apply("vec", i, tbl[i]);

        // Back-pressure: buffer fills, request stops, order preserved on drain
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        apply("bp", 0, mk(0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000));
        apply("bp", 1, mk(0, 16'h0000, 1, 0,   1, 16'h0000, 0, 16'h0000));
        apply("bp", 2, mk(0, 16'h0000, 1, 0,   1, 16'h0002, 1, 16'h0000));
        apply("bp", 3, mk(0, 16'h0000, 0, 0,   0, 16'h0004, 1, 16'h0000));
        apply("bp", 4, mk(0, 16'h0000, 0, 0,   0, 16'h0004, 1, 16'h0000));
        apply("bp", 5, mk(0, 16'h0000, 0, 1,   0, 16'h0004, 1, 16'h0000));
        apply("bp", 6, mk(0, 16'h0000, 0, 1,   0, 16'h0004, 1, 16'h0002));
        apply("bp", 7, mk(0, 16'h0000, 1, 0,   1, 16'h0004, 0, 16'h0000));
        apply("bp", 8, mk(0, 16'h0000, 0, 0,   1, 16'h0006, 1, 16'h0004));

        // Asynchronous reset mid-WAIT with a buffered word
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply("restart", 0, mk(0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000));
        apply("restart", 1, mk(0, 16'h0000, 1, 1,   1, 16'h0000, 0, 16'h0000));
        apply("restart", 2, mk(0, 16'h0000, 0, 1,   1, 16'h0002, 1, 16'h0000));

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
